// File: rtl/stream_accumulator.sv
// Dataflow actor between two fifo_mono instances: pops COUNT tokens from the upstream
// FIFO, sums them modulo 2^DATA_WIDTH and pushes one result token downstream.
module stream_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int COUNT      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  in_read,
    input  logic                  in_empty,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_write,
    input  logic                  out_full
);

    localparam int CNT_W = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        FETCH,
        CAPTURE,
        EMIT
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] sum;
    logic [CNT_W-1:0]      cnt;
    logic                  last_token;

    // Carry-out of the add is dropped on purpose: the result wraps modulo 2^DATA_WIDTH.
    assign sum        = acc + in_dout;
    assign last_token = (cnt == CNT_W'(COUNT - 1));

    // Handshakes are combinational so a pop or push costs no extra cycle; the state
    // gating keeps them mutually exclusive and reset forces both low.
    assign in_read   = rst && !in_empty && (state == FETCH);
    assign out_write = rst && !out_full && (state == EMIT);

    // NOTE: all state lives in this one block and uses non-blocking assignments only,
    // so every register samples the pre-edge values of acc/cnt/state consistently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= FETCH;
            acc     <= '0;
            cnt     <= '0;
            out_din <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (in_read) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // The popped token is on in_dout now: the upstream read is registered.
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                    if (last_token) begin
                        out_din <= sum;
                        state   <= EMIT;
                    end else begin
                        state <= FETCH;
                    end
                end
                EMIT: begin
                    // out_din is left untouched here so it stays stable across a full stall.
                    if (out_write) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: doc/stream_accumulator.md
# stream_accumulator

Dataflow actor that sits directly downstream of a `fifo_mono` instance. It pops tokens from the FIFO read port, sums each group of `COUNT` consecutive tokens modulo 2^`DATA_WIDTH`, and pushes one result token per group into a downstream `fifo_mono` write port. The block uses the same read/write handshake signals as the FIFO, so it chains FIFO → actor → FIFO with no glue logic.

## Interface
- `DATA_WIDTH`, default 8: token width, in bits, on both sides.
- `COUNT`, default 4: number of input tokens per output token. Legal range is 1..256.

- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `in_dout`, input, `DATA_WIDTH`: token from the upstream FIFO `dout`.
- `in_read`, output, 1: pop request to the upstream FIFO `read`.
- `in_empty`, input, 1: upstream FIFO `empty`.
- `out_din`, output, `DATA_WIDTH`: result token to the downstream FIFO `din`.
- `out_write`, output, 1: push request to the downstream FIFO `write`.
- `out_full`, input, 1: downstream FIFO `full`.

## Operation
- **Upstream FIFO contract:**
  - The FIFO has a registered read.
  - `in_dout` is valid in the cycle after the cycle in which `in_read` = 1 was sampled.
- **State machine:** three states, `FETCH`, `CAPTURE` and `EMIT`. Reset state is `FETCH`.
- **Internal registers:**
  - `acc`: `DATA_WIDTH` bits.
  - `cnt`: ceil(log2(`COUNT`+1)) bits.
  - `out_din`: registered.
- **FETCH:**
  - `in_read` = `rst` & !`in_empty` (combinational).
  - If `in_read` = 1, go to `CAPTURE`. Otherwise stay in `FETCH`.
- **CAPTURE:**
  - `acc` <= `acc` + `in_dout`. The carry-out is discarded.
  - `cnt` <= `cnt` + 1.
  - If `cnt` == `COUNT`-1 before the increment:
    - `out_din` <= `acc` + `in_dout`.
    - Go to `EMIT`.
  - Otherwise go to `FETCH`.
  - `in_read` = 0 in this state.
- **EMIT:**
  - `out_write` = !`out_full` (combinational).
  - If `out_write` = 1:
    - `acc` <= 0 and `cnt` <= 0.
    - Go to `FETCH`.
  - If `out_full` = 1: stay in `EMIT`. `out_din` is held stable and no reads are issued.
- **Output gating:**
  - `in_read` is 0 in every state except `FETCH`.
  - `out_write` is 0 in every state except `EMIT`.
  - The block never asserts `in_read` and `out_write` in the same cycle.
- **Arithmetic:** the sum is modulo 2^`DATA_WIDTH`. There is no saturation and no overflow flag.
- **`COUNT` = 1:** every token passes through unchanged, with an `EMIT` after each `CAPTURE`.

## Timing
- **Reset values:**
  - `in_read` = 0 and `out_write` = 0 while `rst` = 0, regardless of `in_empty` and `out_full`.
  - `out_din` = 0, `acc` = 0, `cnt` = 0, state = `FETCH`.
- **Reset mid-operation:** asserting `rst` in any state immediately discards the partial sum and any pending result. No token is emitted.
- **Per-token cost:** 2 cycles (`FETCH` → `CAPTURE`) when `in_empty` = 0.
- **Latency:** with no empty or full stalls, the first pop is at cycle 0 and `out_write` = 1 at cycle 2·`COUNT`.
- **Throughput:** one result per 2·`COUNT`+1 cycles when not stalled.
- **Empty:** `in_empty` = 1 in `FETCH` inserts a stall cycle with no state change. A token is never read from an empty FIFO.
- **Full:** `out_full` = 1 in `EMIT` stalls indefinitely. The result is written in the first cycle in which `out_full` = 0.
- **`in_empty` is ignored outside `FETCH`.** `out_full` is ignored outside `EMIT`.

## Test plan
- **Basic group:** `COUNT`=4, `DATA_WIDTH`=8. Upstream holds 1, 2, 3, 4 and the downstream FIFO is empty → exactly one push with `out_din` = 10, at cycle 8 after the first `in_read`. `in_read` is then 0 while the FIFO is empty.
- **Wrap-around:** tokens 200, 100, 0, 0 → `out_din` = 44. A second group 255, 255, 255, 255 → 252.
- **Backpressure:** hold `out_full` = 1 for 5 cycles on entry to `EMIT` with tokens 5, 5, 5, 5:
  - `out_write` stays 0 and `out_din` holds 20.
  - No `in_read` pulses occur.
  - On release there is a single push of 20.
- **Empty bubbles:** upstream `in_empty` toggles every cycle with 8 tokens of value 1 → two pushes of 4 each. `in_read` is never 1 while `in_empty` = 1.
- **Reset mid-group:** after 2 tokens, pulse `rst` low for 1 cycle:
  - `in_read`, `out_write` and `out_din` read 0 during the pulse.
  - The next 4 tokens 1, 1, 1, 1 yield `out_din` = 4. The pre-reset tokens contribute nothing.
- **`COUNT` = 1:** tokens 7, 9 → pushes 7 then 9, each 2 cycles after its read.
